// File: rtl/superscalar_pkg.sv
// Shared widths and the per-lane control bundle
// for the dual-issue EX->MEM boundary.
package superscalar_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic                  regWrite;
        logic                  memRead;
        logic                  memWrite;
        logic [REG_ADDR_W-1:0] rd;
    } lane_ctrl_t;

endpackage

// File: rtl/exmem_lane_reg.sv
// One lane of the EX->MEM register: hold on stall,
// capture on advance, side-effect controls gated by accept.
module exmem_lane_reg
    import superscalar_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            acc,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] aluResult,
    input  logic [XLEN-1:0] storeData,
    input  lane_ctrl_t      ctrl,
    output logic            memValid,
    output logic [XLEN-1:0] memPc,
    output logic [XLEN-1:0] memAluResult,
    output logic [XLEN-1:0] memStoreData,
    output lane_ctrl_t      memCtrl
);

    always_ff @(posedge clk) begin
        if (rst) begin
            memValid     <= 1'b0;
            memPc        <= '0;
            memAluResult <= '0;
            memStoreData <= '0;
            memCtrl      <= '0;
        end else if (!stall) begin
            memValid         <= acc;
            memPc            <= pc;
            memAluResult     <= aluResult;
            memStoreData     <= storeData;
            // a killed lane keeps its data but must not write anything
            memCtrl.regWrite <= ctrl.regWrite & acc;
            memCtrl.memRead  <= ctrl.memRead & acc;
            memCtrl.memWrite <= ctrl.memWrite & acc;
            memCtrl.rd       <= ctrl.rd;
        end
    end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// Dual-lane EX->MEM register with branch redirect and wrong-path shadow.
// Optional EXMEM_PERF_EN adds takenCount / killCount ports.
module ex_mem_stage_reg
    import superscalar_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  exValid1,
    input  logic                  exValid2,
    input  logic [XLEN-1:0]       pc1,
    input  logic [XLEN-1:0]       pc2,
    input  logic [XLEN-1:0]       aluResult1,
    input  logic [XLEN-1:0]       aluResult2,
    input  logic                  isBranchTaken1,
    input  logic                  isBranchTaken2,
    input  logic [XLEN-1:0]       branchPC1,
    input  logic [XLEN-1:0]       branchPC2,
    input  logic [REG_ADDR_W-1:0] rd1,
    input  logic [REG_ADDR_W-1:0] rd2,
    input  logic                  regWrite1,
    input  logic                  regWrite2,
    input  logic                  memRead1,
    input  logic                  memRead2,
    input  logic                  memWrite1,
    input  logic                  memWrite2,
    input  logic [XLEN-1:0]       storeData1,
    input  logic [XLEN-1:0]       storeData2,
    output logic                  memValid1,
    output logic                  memValid2,
    output logic [XLEN-1:0]       memPc1,
    output logic [XLEN-1:0]       memPc2,
    output logic [XLEN-1:0]       memAluResult1,
    output logic [XLEN-1:0]       memAluResult2,
    output logic [XLEN-1:0]       memStoreData1,
    output logic [XLEN-1:0]       memStoreData2,
    output logic [REG_ADDR_W-1:0] memRd1,
    output logic [REG_ADDR_W-1:0] memRd2,
    output logic                  memRegWrite1,
    output logic                  memRegWrite2,
    output logic                  memMemRead1,
    output logic                  memMemRead2,
    output logic                  memMemWrite1,
    output logic                  memMemWrite2,
    output logic                  redirectValid,
    output logic [XLEN-1:0]       redirectPC,
`ifdef EXMEM_PERF_EN
    output logic [31:0]           takenCount,
    output logic [31:0]           killCount,
`endif
    output logic                  squashFront
);

    localparam int SW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [SW-1:0] SHADOW_LOAD = SW'(FLUSH_CYCLES);

    logic [SW-1:0] shadow;
    logic          acc1;
    logic          acc2;
    logic          launch1;
    logic          launch2;
    lane_ctrl_t    ctrl1;
    lane_ctrl_t    ctrl2;
    lane_ctrl_t    mctrl1;
    lane_ctrl_t    mctrl2;

    assign acc1    = exValid1 & (shadow == '0);
    assign acc2    = exValid2 & (shadow == '0) & ~(exValid1 & isBranchTaken1);
    assign launch1 = acc1 & isBranchTaken1;
    assign launch2 = acc2 & isBranchTaken2;

    assign ctrl1 = {regWrite1, memRead1, memWrite1, rd1};
    assign ctrl2 = {regWrite2, memRead2, memWrite2, rd2};

    exmem_lane_reg u_lane1 (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .acc          (acc1),
        .pc           (pc1),
        .aluResult    (aluResult1),
        .storeData    (storeData1),
        .ctrl         (ctrl1),
        .memValid     (memValid1),
        .memPc        (memPc1),
        .memAluResult (memAluResult1),
        .memStoreData (memStoreData1),
        .memCtrl      (mctrl1)
    );

    exmem_lane_reg u_lane2 (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .acc          (acc2),
        .pc           (pc2),
        .aluResult    (aluResult2),
        .storeData    (storeData2),
        .ctrl         (ctrl2),
        .memValid     (memValid2),
        .memPc        (memPc2),
        .memAluResult (memAluResult2),
        .memStoreData (memStoreData2),
        .memCtrl      (mctrl2)
    );

    assign memRd1       = mctrl1.rd;
    assign memRd2       = mctrl2.rd;
    assign memRegWrite1 = mctrl1.regWrite;
    assign memRegWrite2 = mctrl2.regWrite;
    assign memMemRead1  = mctrl1.memRead;
    assign memMemRead2  = mctrl2.memRead;
    assign memMemWrite1 = mctrl1.memWrite;
    assign memMemWrite2 = mctrl2.memWrite;

    // a stalled edge still retires the pulse but never launches
    always_ff @(posedge clk) begin
        if (rst) begin
            redirectValid <= 1'b0;
            redirectPC    <= '0;
            shadow        <= '0;
        end else if (stall) begin
            redirectValid <= 1'b0;
        end else begin
            redirectValid <= launch1 | launch2;
            if (launch1) begin
                redirectPC <= branchPC1;
            end else if (launch2) begin
                redirectPC <= branchPC2;
            end
            if (launch1 | launch2) begin
                shadow <= SHADOW_LOAD;
            end else if (shadow != '0) begin
                shadow <= shadow - SW'(1);
            end
        end
    end

    assign squashFront = redirectValid | (shadow != '0);

`ifdef EXMEM_PERF_EN
    logic [1:0] nkill;

    assign nkill = {1'b0, exValid1 & ~acc1} + {1'b0, exValid2 & ~acc2};

    always_ff @(posedge clk) begin
        if (rst) begin
            takenCount <= '0;
            killCount  <= '0;
        end else if (!stall) begin
            takenCount <= takenCount + 32'(launch1 | launch2);
            killCount  <= killCount + 32'(nkill);
        end
    end
`endif

endmodule
